// File: rtl/axi4lite_cmd_sequencer.sv
// axi4lite_cmd_sequencer
// Command front-end sitting directly upstream of the AXI4-Lite master.
// Write/read commands are buffered in a small FIFO, issued one at a time as
// single-cycle start_write/start_read pulses, and each completion (done) is
// returned as one response on a valid/ready port.
// Optional build macro: CMDSEQ_TIMEOUT_EN enables a WAIT-state watchdog that
// aborts a command with rsp_err=1 after TIMEOUT_CYCLES cycles without done.
module axi4lite_cmd_sequencer #(
  parameter int ADDR_WIDTH     = 2,
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rw,
  input  logic [ADDR_WIDTH-1:0]       cmd_addr,
  input  logic [DATA_WIDTH-1:0]       cmd_wdata,
  output logic                        start_write,
  output logic                        start_read,
  output logic [ADDR_WIDTH-1:0]       write_addr,
  output logic [ADDR_WIDTH-1:0]       read_addr,
  output logic [DATA_WIDTH-1:0]       write_data,
  input  logic                        done,
  input  logic [DATA_WIDTH-1:0]       read_data,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic                        rsp_rw,
  output logic [DATA_WIDTH-1:0]       rsp_data,
  output logic                        rsp_err,
  output logic                        busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;

  // Reject parameter values the pointer arithmetic cannot handle
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_next;

  logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    fifo_head;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;

  logic                  hold_rw;
  logic [ADDR_WIDTH-1:0] hold_addr;
  logic [DATA_WIDTH-1:0] hold_wdata;

  logic                  wait_done;
  logic                  wait_timeout;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign push       = cmd_valid && !fifo_full;
  assign pop        = (state == IDLE) && !fifo_empty;
  assign fifo_head  = fifo_mem[rd_ptr];
  assign wait_done  = (state == WAIT) && done;

  assign cmd_ready  = !fifo_full;
  assign fifo_count = count;
  assign busy       = (state != IDLE) || !fifo_empty;

  // Command storage; contents need no reset because count guards every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {cmd_rw, cmd_addr, cmd_wdata};
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Holding registers keep the active command stable from ISSUE until WAIT ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_rw    <= 1'b0;
      hold_addr  <= '0;
      hold_wdata <= '0;
    end else if (pop) begin
      hold_rw    <= fifo_head[ENTRY_W-1];
      hold_addr  <= fifo_head[DATA_WIDTH +: ADDR_WIDTH];
      hold_wdata <= fifo_head[DATA_WIDTH-1:0];
    end
  end

`ifdef CMDSEQ_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] wait_timer;

  // Watchdog counts cycles spent in WAIT; cleared during ISSUE so it starts at 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_timer <= '0;
    end else if (state == ISSUE) begin
      wait_timer <= '0;
    end else if (state == WAIT) begin
      wait_timer <= wait_timer + 1'b1;
    end
  end

  assign wait_timeout = (state == WAIT) && !done &&
                        (wait_timer == TMR_W'(TIMEOUT_CYCLES - 1));
`else
  assign wait_timeout = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // FSM next-state logic; done is only meaningful in WAIT
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!fifo_empty) state_next = ISSUE;
      ISSUE:   state_next = WAIT;
      WAIT:    if (wait_done || wait_timeout) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: one-cycle start pulse in ISSUE, address/data held through WAIT
  always_comb begin
    start_write = 1'b0;
    start_read  = 1'b0;
    write_addr  = '0;
    read_addr   = '0;
    write_data  = '0;
    if (state == ISSUE || state == WAIT) begin
      if (hold_rw) begin
        write_addr = hold_addr;
        write_data = hold_wdata;
      end else begin
        read_addr  = hold_addr;
      end
    end
    if (state == ISSUE) begin
      start_write = hold_rw;
      start_read  = !hold_rw;
    end
  end

  // Response register: loaded on completion or abort, held until accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rw    <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else if (wait_done || wait_timeout) begin
      rsp_valid <= 1'b1;
      rsp_rw    <= hold_rw;
      rsp_data  <= (wait_done && !hold_rw) ? read_data : '0;
      rsp_err   <= !wait_done;
    end else if (state == RESP && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
